// File: rtl/fb_pkg.sv
// Shared definitions for the double-buffered frame buffer arbiter:
// default geometry (640x480, 1 bit per pixel) and the arbiter FSM state set.
package fb_pkg;

    localparam int FB_ADDR_WIDTH    = 19;
    localparam int FB_DEPTH_DEFAULT = 307200;

    typedef enum logic [1:0] {
        CLEAR_BOTH = 2'd0,
        CLEAR      = 2'd1,
        DRAW       = 2'd2,
        READY      = 2'd3
    } fb_state_e;

endpackage

// File: rtl/frame_buffer_arbiter.sv
// Double-buffer arbiter between a pixel plotter (writes the back buffer) and
// a display scanner (reads the front buffer) sharing two external 1-bit BRAMs.
//
// Ports:
//   clk, rst                   clock, async active-high reset
//   wr_req/wr_addr/wr_data     plotter write, accepted when wr_gnt=1
//   frame_done                 plotter finished drawing the back buffer
//   rd_req/rd_addr             scanner read of the front buffer
//   rd_data/rd_valid           read result, one cycle after rd_req
//   frame_end                  vsync pulse; swap point when a frame is ready
//   WE0/WE1, addrB0/addrB1, WD BRAM0/BRAM1 write enables, addresses, shared data
//   RD0/RD1                    BRAM read data (1-cycle latency)
//   front_sel, swap            displayed buffer, one-cycle swap pulse
//   repeat_cnt                 saturating count of vsyncs with no new frame
module frame_buffer_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int FB_DEPTH   = FB_DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  wr_data,
    output logic                  wr_gnt,
    input  logic                  frame_done,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_data,
    output logic                  rd_valid,
    input  logic                  frame_end,
    output logic                  WE0,
    output logic                  WE1,
    output logic [ADDR_WIDTH-1:0] addrB0,
    output logic [ADDR_WIDTH-1:0] addrB1,
    output logic                  WD,
    input  logic                  RD0,
    input  logic                  RD1,
    output logic                  front_sel,
    output logic                  swap,
    output logic [15:0]           repeat_cnt
);

    // FB_DEPTH may equal 2**ADDR_WIDTH, so the range check needs one extra bit.
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST  = ADDR_WIDTH'(FB_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(FB_DEPTH);

    fb_state_e             state;
    fb_state_e             state_nx;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [ADDR_WIDTH-1:0] clr_cnt_nx;
    logic                  do_swap;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  rd_sel_q;
    logic                  back_we;
    logic [ADDR_WIDTH-1:0] back_addr;
    logic [ADDR_WIDTH-1:0] front_addr;
    logic                  wr_in_range;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);

    // State register and bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CLEAR_BOTH;
            clr_cnt    <= '0;
            front_sel  <= 1'b0;
            repeat_cnt <= 16'd0;
            rd_addr_q  <= '0;
            rd_sel_q   <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
            if (do_swap) begin
                front_sel <= ~front_sel;
            end
            // A vsync that finds no finished frame repeats the old image.
            if (frame_end && (state != READY) && (repeat_cnt != 16'hFFFF)) begin
                repeat_cnt <= repeat_cnt + 16'd1;
            end
            if (rd_req) begin
                rd_addr_q <= rd_addr;
                rd_sel_q  <= front_sel;
            end
            rd_valid <= rd_req;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        do_swap    = 1'b0;
        unique case (state)
            CLEAR_BOTH, CLEAR: begin
                if (clr_cnt == CLR_LAST) begin
                    state_nx   = DRAW;
                    clr_cnt_nx = '0;
                end else begin
                    clr_cnt_nx = clr_cnt + 1'b1;
                end
            end
            DRAW: begin
                if (frame_done) begin
                    state_nx = READY;
                end
            end
            READY: begin
                if (frame_end) begin
                    state_nx   = CLEAR;
                    clr_cnt_nx = '0;
                    do_swap    = 1'b1;
                end
            end
        endcase
    end

    // BRAM port steering. Outputs are forced idle while rst is held so the
    // BRAMs see no writes during reset even though state is CLEAR_BOTH.
    always_comb begin
        WE0        = 1'b0;
        WE1        = 1'b0;
        addrB0     = '0;
        addrB1     = '0;
        WD         = 1'b0;
        wr_gnt     = 1'b0;
        swap       = 1'b0;
        back_we    = 1'b0;
        back_addr  = wr_addr;
        front_addr = rd_req ? rd_addr : rd_addr_q;
        if (!rst) begin
            unique case (state)
                CLEAR_BOTH: begin
                    WE0    = 1'b1;
                    WE1    = 1'b1;
                    addrB0 = clr_cnt;
                    addrB1 = clr_cnt;
                end
                CLEAR: begin
                    back_we   = 1'b1;
                    back_addr = clr_cnt;
                end
                DRAW: begin
                    wr_gnt  = 1'b1;
                    WD      = wr_data;
                    back_we = wr_req && wr_in_range;
                end
                READY: begin
                    swap = frame_end;
                end
            endcase
            // Outside CLEAR_BOTH the front port only ever reads.
            if (state != CLEAR_BOTH) begin
                WE0    = front_sel ? back_we : 1'b0;
                WE1    = front_sel ? 1'b0 : back_we;
                addrB0 = front_sel ? back_addr : front_addr;
                addrB1 = front_sel ? front_addr : back_addr;
            end
        end
    end

    // BRAM data arrives one cycle after the address; select with the
    // front buffer captured on the request cycle.
    assign rd_data = rd_valid & (rd_sel_q ? RD1 : RD0);

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Self-checking bench for frame_buffer_arbiter with a 16-pixel buffer.
// Directed vector table for DRAW cycles plus hand sequences for multi-cycle cases.
module tb_frame_buffer_arbiter;

    localparam int AW    = 5;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic          wr_data;
    logic          wr_gnt;
    logic          frame_done;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_data;
    logic          rd_valid;
    logic          frame_end;
    logic          WE0;
    logic          WE1;
    logic [AW-1:0] addrB0;
    logic [AW-1:0] addrB1;
    logic          WD;
    logic          RD0;
    logic          RD1;
    logic          front_sel;
    logic          swap;
    logic [15:0]   repeat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    frame_buffer_arbiter #(
        .ADDR_WIDTH (AW),
        .FB_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_gnt     (wr_gnt),
        .frame_done (frame_done),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .frame_end  (frame_end),
        .WE0        (WE0),
        .WE1        (WE1),
        .addrB0     (addrB0),
        .addrB1     (addrB1),
        .WD         (WD),
        .RD0        (RD0),
        .RD1        (RD1),
        .front_sel  (front_sel),
        .swap       (swap),
        .repeat_cnt (repeat_cnt)
    );

    typedef struct {
        logic          wr_req;
        logic [AW-1:0] wr_addr;
        logic          wr_data;
        logic          rd_req;
        logic [AW-1:0] rd_addr;
        logic          we0;
        logic          we1;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic          wd;
        logic          rv;
        logic          rdd;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_req     = 1'b0;
        wr_addr    = '0;
        wr_data    = 1'b0;
        frame_done = 1'b0;
        rd_req     = 1'b0;
        rd_addr    = '0;
        frame_end  = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we0"}, 32'(WE0), 32'd0);
        chk({tag, "_we1"}, 32'(WE1), 32'd0);
        chk({tag, "_a0"}, 32'(addrB0), 32'd0);
        chk({tag, "_a1"}, 32'(addrB1), 32'd0);
        chk({tag, "_wd"}, 32'(WD), 32'd0);
        chk({tag, "_gnt"}, 32'(wr_gnt), 32'd0);
        chk({tag, "_swap"}, 32'(swap), 32'd0);
        chk({tag, "_front"}, 32'(front_sel), 32'd0);
        chk({tag, "_rv"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rdd"}, 32'(rd_data), 32'd0);
        chk({tag, "_rep"}, 32'(repeat_cnt), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Distinct BRAM read data so the selected buffer is observable.
        RD0 = 1'b1;
        RD1 = 1'b0;
        idle();
        rst = 1'b0;
        #1 rst = 1'b1;

        vecs[0] = '{1'b1, 5'd5,  1'b1, 1'b0, 5'd3,
                    1'b0, 1'b1, 5'd0,  5'd5,  1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 5'd20, 1'b1, 1'b0, 5'd3,
                    1'b0, 1'b0, 5'd0,  5'd20, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 5'd15, 1'b0, 1'b1, 5'd7,
                    1'b0, 1'b1, 5'd7,  5'd15, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 5'd9,  1'b1, 1'b0, 5'd2,
                    1'b0, 1'b0, 5'd7,  5'd9,  1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 5'd16, 1'b1, 1'b1, 5'd31,
                    1'b0, 1'b0, 5'd31, 5'd16, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 5'd0,  1'b1, 1'b0, 5'd2,
                    1'b0, 1'b1, 5'd31, 5'd0,  1'b1, 1'b1, 1'b1};

        tick();
        tick();
        chk_reset_outputs("rst");

        // Release reset: clear both buffers, 16 cycles.
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #2;
            chk("cb_we0", 32'(WE0), 32'd1);
            chk("cb_we1", 32'(WE1), 32'd1);
            chk("cb_a0", 32'(addrB0), 32'(i));
            chk("cb_a1", 32'(addrB1), 32'(i));
            chk("cb_wd", 32'(WD), 32'd0);
            chk("cb_gnt", 32'(wr_gnt), 32'd0);
            tick();
        end

        // DRAW vectors, front buffer is BRAM0.
        for (int v = 0; v < 6; v++) begin
            wr_req  = vecs[v].wr_req;
            wr_addr = vecs[v].wr_addr;
            wr_data = vecs[v].wr_data;
            rd_req  = vecs[v].rd_req;
            rd_addr = vecs[v].rd_addr;
            #2;
            chk($sformatf("v%0d_gnt", v), 32'(wr_gnt), 32'd1);
            chk($sformatf("v%0d_we0", v), 32'(WE0), 32'(vecs[v].we0));
            chk($sformatf("v%0d_we1", v), 32'(WE1), 32'(vecs[v].we1));
            chk($sformatf("v%0d_a0", v), 32'(addrB0), 32'(vecs[v].a0));
            chk($sformatf("v%0d_a1", v), 32'(addrB1), 32'(vecs[v].a1));
            chk($sformatf("v%0d_wd", v), 32'(WD), 32'(vecs[v].wd));
            chk($sformatf("v%0d_rv", v), 32'(rd_valid), 32'(vecs[v].rv));
            chk($sformatf("v%0d_rdd", v), 32'(rd_data), 32'(vecs[v].rdd));
            tick();
        end

        // frame_done: grant still high this cycle, gone the next.
        idle();
        frame_done = 1'b1;
        #2;
        chk("done_gnt", 32'(wr_gnt), 32'd1);
        tick();
        idle();
        wr_req  = 1'b1;
        wr_addr = 5'd3;
        wr_data = 1'b1;
        #2;
        chk("ready_gnt", 32'(wr_gnt), 32'd0);
        chk("ready_we0", 32'(WE0), 32'd0);
        chk("ready_we1", 32'(WE1), 32'd0);
        tick();

        // Swap with a read issued on the swap cycle.
        idle();
        frame_end = 1'b1;
        rd_req    = 1'b1;
        rd_addr   = 5'd4;
        #2;
        chk("swap_pulse", 32'(swap), 32'd1);
        chk("swap_front", 32'(front_sel), 32'd0);
        chk("swap_a0", 32'(addrB0), 32'd4);
        chk("swap_we0", 32'(WE0), 32'd0);
        chk("swap_we1", 32'(WE1), 32'd0);
        tick();
        idle();
        #2;
        chk("post_front", 32'(front_sel), 32'd1);
        chk("post_rv", 32'(rd_valid), 32'd1);
        chk("post_rdd_oldfront", 32'(rd_data), 32'd1);

        // CLEAR of BRAM0, with one ignored vsync in the middle.
        for (int i = 0; i < DEPTH; i++) begin
            frame_end = (i == 3);
            #2;
            chk("clr_we0", 32'(WE0), 32'd1);
            chk("clr_a0", 32'(addrB0), 32'(i));
            chk("clr_we1", 32'(WE1), 32'd0);
            chk("clr_a1", 32'(addrB1), 32'd4);
            chk("clr_wd", 32'(WD), 32'd0);
            chk("clr_gnt", 32'(wr_gnt), 32'd0);
            chk("clr_swap", 32'(swap), 32'd0);
            chk("clr_front", 32'(front_sel), 32'd1);
            tick();
        end

        // DRAW: vsync alone, then vsync together with frame_done.
        idle();
        frame_end = 1'b1;
        #2;
        chk("d1_gnt", 32'(wr_gnt), 32'd1);
        chk("d1_rep", 32'(repeat_cnt), 32'd1);
        tick();
        frame_done = 1'b1;
        #2;
        chk("d2_rep", 32'(repeat_cnt), 32'd2);
        chk("d2_swap", 32'(swap), 32'd0);
        tick();
        idle();
        frame_end = 1'b1;
        #2;
        chk("d3_gnt", 32'(wr_gnt), 32'd0);
        chk("d3_rep", 32'(repeat_cnt), 32'd3);
        chk("d3_front", 32'(front_sel), 32'd1);
        chk("d3_swap", 32'(swap), 32'd1);
        tick();
        idle();
        #2;
        chk("d4_front", 32'(front_sel), 32'd0);
        chk("d4_rep", 32'(repeat_cnt), 32'd3);
        chk("d4_we1", 32'(WE1), 32'd1);
        chk("d4_a1", 32'(addrB1), 32'd0);
        chk("d4_we0", 32'(WE0), 32'd0);
        chk("d4_a0_hold", 32'(addrB0), 32'd4);
        tick();
        rd_req  = 1'b1;
        rd_addr = 5'd9;
        #2;
        chk("d5_a0", 32'(addrB0), 32'd9);
        chk("d5_a1", 32'(addrB1), 32'd1);
        tick();
        idle();
        #2;
        chk("d6_rv", 32'(rd_valid), 32'd1);
        chk("d6_rdd", 32'(rd_data), 32'd1);
        chk("d6_a1", 32'(addrB1), 32'd2);

        // Reset mid-CLEAR: outputs drop immediately.
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        tick();
        tick();
        rst = 1'b0;
        #2;
        chk("rr0_we0", 32'(WE0), 32'd1);
        chk("rr0_we1", 32'(WE1), 32'd1);
        chk("rr0_a0", 32'(addrB0), 32'd0);
        chk("rr0_a1", 32'(addrB1), 32'd0);
        tick();
        #2;
        chk("rr1_a0", 32'(addrB0), 32'd1);
        for (int i = 2; i <= DEPTH; i++) begin
            tick();
        end
        #2;
        chk("rr_draw_gnt", 32'(wr_gnt), 32'd1);

        // Saturation: hold vsync in DRAW well past 65535.
        frame_end = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            tick();
        end
        frame_end = 1'b0;
        #2;
        chk("sat_rep", 32'(repeat_cnt), 32'hFFFF);
        chk("sat_front", 32'(front_sel), 32'd0);
        chk("sat_gnt", 32'(wr_gnt), 32'd1);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        #2;
        chk("sat_hold", 32'(repeat_cnt), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
